cla_addsub_seq: RTL and testbench

- Parametrised, multi-cycle add/subtract unit for the calculator datapath, built from 4-bit carry-lookahead groups.
- Carry ripples between groups through a register, so wide operands are processed over several cycles with small lookahead logic.
- Operands are captured on a start pulse. Results and status flags are published with a one-cycle done pulse and held until the next operation completes.

---
 rtl/cla_addsub_seq.sv | 190 +++++++++++++++++++
 tb/tb_cla_addsub_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_seq.sv
// Multi-cycle add/subtract unit built from 4-bit carry-lookahead groups.
// GROUPS_PER_CYCLE groups are evaluated per clock; the carry between steps
// is held in a register, so a WIDTH-bit operation takes (WIDTH/4)/GROUPS_PER_CYCLE
// cycles after the operands are captured.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   start               - begin an operation (sampled only while idle)
//   a, b                - operands
//   add_sub_control     - 0: a+b, 1: a-b
//   busy                - operation in progress
//   done                - one-cycle pulse when result/flags are updated
//   result              - sum/difference, held between operations
//   carry_out           - carry out of MSB (for subtract, 1 = no borrow)
//   overflow            - signed overflow
//   zero, negative      - status of result
module cla_addsub_seq #(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned GROUPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned NG       = WIDTH / 4;
    localparam int unsigned IDX_W    = (NG > 1) ? $clog2(NG) : 1;
    localparam int unsigned LAST_IDX = NG - GROUPS_PER_CYCLE;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    // 4-bit lookahead group: returns {c3, c2, sum[3:0]}; c2 is the carry into bit 3
    function automatic logic [5:0] cla4(input logic [3:0] p, input logic [3:0] g,
                                        input logic cin);
        logic c0, c1, c2, c3;
        logic [3:0] s;
        c0 = g[0] | (p[0] & cin);
        c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
        s  = p ^ {c2, c1, c0, cin};
        return {c3, c2, s};
    endfunction

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;

    // datapath of one compute step
    logic [WIDTH-1:0] step_acc;
    logic             step_cin;
    logic             step_msb_cin;
    logic [3:0]       grp_p;
    logic [3:0]       grp_g;
    logic [5:0]       grp_out;
    int unsigned      base;

    // One compute step: GROUPS_PER_CYCLE groups chained combinationally
    always_comb begin
        step_acc     = acc_q;
        step_cin     = carry_q;
        step_msb_cin = 1'b0;
        grp_p        = '0;
        grp_g        = '0;
        grp_out      = '0;
        base         = 0;
        for (int unsigned j = 0; j < GROUPS_PER_CYCLE; j++) begin
            base                = (32'(idx_q) + j) << 2;
            grp_p               = a_q[base +: 4] ^ b_q[base +: 4];
            grp_g               = a_q[base +: 4] & b_q[base +: 4];
            grp_out             = cla4(grp_p, grp_g, step_cin);
            step_acc[base +: 4] = grp_out[3:0];
            step_msb_cin        = grp_out[4];
            step_cin            = grp_out[5];
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{add_sub_control}};
                    carry_d = add_sub_control;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d   = step_acc;
                carry_d = step_cin;
                if (32'(idx_q) == LAST_IDX) begin
                    // the last group of the final step contains the MSB
                    result_d    = step_acc;
                    carry_out_d = step_cin;
                    overflow_d  = step_msb_cin ^ step_cin;
                    zero_d      = (step_acc == '0);
                    negative_d  = step_acc[WIDTH-1];
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    idx_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(GROUPS_PER_CYCLE);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Bench for cla_addsub_seq: four configurations (8/1, 16/2, 4/1, 8/2) against an
// arithmetic reference model checked every cycle, plus directed literal checks.
module tb_cla_addsub_seq;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    logic        st  [NI];
    logic [15:0] ai  [NI];
    logic [15:0] bi  [NI];
    logic        op  [NI];

    logic        o_busy [NI];
    logic        o_done [NI];
    logic [15:0] o_res  [NI];
    logic        o_c    [NI];
    logic        o_v    [NI];
    logic        o_z    [NI];
    logic        o_n    [NI];

    logic [7:0]  r0;
    logic [15:0] r1;
    logic [3:0]  r2;
    logic [7:0]  r3;

    int n_vec = 0;
    int n_bad = 0;

    function automatic int w_of(int i);
        case (i)
            0: return 8;
            1: return 16;
            2: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int g_of(int i);
        return (i == 1 || i == 3) ? 2 : 1;
    endfunction

    function automatic int c_of(int i);
        return (w_of(i) / 4) / g_of(i);
    endfunction

    cla_addsub_seq #(.WIDTH(8), .GROUPS_PER_CYCLE(1)) u0 (
        .clk(clk), .reset(reset), .start(st[0]), .a(ai[0][7:0]), .b(bi[0][7:0]),
        .add_sub_control(op[0]), .busy(o_busy[0]), .done(o_done[0]), .result(r0),
        .carry_out(o_c[0]), .overflow(o_v[0]), .zero(o_z[0]), .negative(o_n[0]));

    cla_addsub_seq #(.WIDTH(16), .GROUPS_PER_CYCLE(2)) u1 (
        .clk(clk), .reset(reset), .start(st[1]), .a(ai[1]), .b(bi[1]),
        .add_sub_control(op[1]), .busy(o_busy[1]), .done(o_done[1]), .result(r1),
        .carry_out(o_c[1]), .overflow(o_v[1]), .zero(o_z[1]), .negative(o_n[1]));

    cla_addsub_seq #(.WIDTH(4), .GROUPS_PER_CYCLE(1)) u2 (
        .clk(clk), .reset(reset), .start(st[2]), .a(ai[2][3:0]), .b(bi[2][3:0]),
        .add_sub_control(op[2]), .busy(o_busy[2]), .done(o_done[2]), .result(r2),
        .carry_out(o_c[2]), .overflow(o_v[2]), .zero(o_z[2]), .negative(o_n[2]));

    cla_addsub_seq #(.WIDTH(8), .GROUPS_PER_CYCLE(2)) u3 (
        .clk(clk), .reset(reset), .start(st[3]), .a(ai[3][7:0]), .b(bi[3][7:0]),
        .add_sub_control(op[3]), .busy(o_busy[3]), .done(o_done[3]), .result(r3),
        .carry_out(o_c[3]), .overflow(o_v[3]), .zero(o_z[3]), .negative(o_n[3]));

    assign o_res[0] = 16'(r0);
    assign o_res[1] = r1;
    assign o_res[2] = 16'(r2);
    assign o_res[3] = 16'(r3);

    // Reference arithmetic: plain modular add with two's-complement sign rules
    function automatic void ref_calc(input int w, input logic [15:0] a, input logic [15:0] b,
                                     input logic sub, output logic [15:0] r,
                                     output logic c, output logic v);
        logic [16:0] mask;
        logic [16:0] s;
        logic sa, sb, sr;
        mask = (17'd1 << w) - 17'd1;
        s    = (17'(a) & mask) + ((17'(b) ^ (sub ? mask : 17'd0)) & mask) + 17'(sub);
        r    = s[15:0] & mask[15:0];
        c    = s[w];
        sa   = a[w-1];
        sb   = b[w-1];
        sr   = r[w-1];
        v    = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

    // model state
    logic        m_busy [NI];
    int          m_cnt  [NI];
    logic [15:0] p_r    [NI];
    logic        p_c    [NI];
    logic        p_v    [NI];
    logic        e_busy [NI];
    logic        e_done [NI];
    logic [15:0] e_res  [NI];
    logic        e_c    [NI];
    logic        e_v    [NI];
    logic        e_z    [NI];
    logic        e_n    [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 1'b0; m_cnt[i] = 0; p_r[i] = '0; p_c[i] = 1'b0; p_v[i] = 1'b0;
            e_busy[i] = 1'b0; e_done[i] = 1'b0; e_res[i] = '0;
            e_c[i] = 1'b0; e_v[i] = 1'b0; e_z[i] = 1'b0; e_n[i] = 1'b0;
        end
    end

    // Model update at each edge, then compare all outputs shortly after it
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            e_done[i] = 1'b0;
            if (reset) begin
                m_busy[i] = 1'b0; m_cnt[i] = 0; e_res[i] = '0;
                e_c[i] = 1'b0; e_v[i] = 1'b0; e_z[i] = 1'b0; e_n[i] = 1'b0;
            end else if (m_busy[i]) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) begin
                    e_res[i]  = p_r[i];
                    e_c[i]    = p_c[i];
                    e_v[i]    = p_v[i];
                    e_z[i]    = (p_r[i] == 16'd0);
                    e_n[i]    = p_r[i][w_of(i)-1];
                    m_busy[i] = 1'b0;
                    e_done[i] = 1'b1;
                end
            end else if (st[i]) begin
                ref_calc(w_of(i), ai[i], bi[i], op[i], p_r[i], p_c[i], p_v[i]);
                m_busy[i] = 1'b1;
                m_cnt[i]  = c_of(i);
            end
            e_busy[i] = m_busy[i];
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({o_busy[i], o_done[i], o_res[i], o_c[i], o_v[i], o_z[i], o_n[i]} !==
                {e_busy[i], e_done[i], e_res[i], e_c[i], e_v[i], e_z[i], e_n[i]}) begin
                n_bad++;
                $display("FAIL cycle inst%0d t=%0t got busy=%b done=%b res=%h c=%b v=%b z=%b n=%b exp busy=%b done=%b res=%h c=%b v=%b z=%b n=%b",
                         i, $time, o_busy[i], o_done[i], o_res[i], o_c[i], o_v[i], o_z[i], o_n[i],
                         e_busy[i], e_done[i], e_res[i], e_c[i], e_v[i], e_z[i], e_n[i]);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input int i, input string name, input int r,
                           input logic c, input logic v, input logic z, input logic n);
        chk({name, "_res"}, int'(o_res[i]), r);
        chk({name, "_cvzn"}, int'({o_c[i], o_v[i], o_z[i], o_n[i]}), int'({c, v, z, n}));
    endtask

    // Caller is at a negedge; start is held for one edge, then inputs are scrambled
    task automatic start_op(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic sub);
        st[i] = 1'b1; ai[i] = a; bi[i] = b; op[i] = sub;
        @(negedge clk);
        st[i] = 1'b0; ai[i] = 16'($urandom); bi[i] = 16'($urandom); op[i] = 1'($urandom);
    endtask

    // Count negedges until done is seen (bounded) and check the count
    task automatic wait_done(input int i, input int exp_lat, input string name);
        int lat;
        lat = 0;
        while (!o_done[i] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            st[i] = 1'b0; ai[i] = '0; bi[i] = '0; op[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy_done", int'({o_busy[0], o_done[0]}), 0);
        chk_out(0, "rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // basic add, latency 2
        start_op(0, 16'd100, 16'd27, 1'b0);
        chk("t1_busy", int'(o_busy[0]), 1);
        wait_done(0, 2, "t1");
        chk_out(0, "t1", 127, 1'b0, 1'b0, 1'b0, 1'b0);

        start_op(0, 16'h7f, 16'h01, 1'b0);
        wait_done(0, 2, "t2a");
        chk_out(0, "t2a", 'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        start_op(0, 16'hff, 16'h01, 1'b0);
        wait_done(0, 2, "t2b");
        chk_out(0, "t2b", 'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // subtracts
        start_op(0, 16'd5, 16'd5, 1'b1);
        wait_done(0, 2, "t3a");
        chk_out(0, "t3a", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        start_op(0, 16'd3, 16'd5, 1'b1);
        wait_done(0, 2, "t3b");
        chk_out(0, "t3b", 'hfe, 1'b0, 1'b0, 1'b0, 1'b1);
        start_op(0, 16'h80, 16'h01, 1'b1);
        wait_done(0, 2, "t3c");
        chk_out(0, "t3c", 'h7f, 1'b1, 1'b1, 1'b0, 1'b0);

        // start while busy is ignored; start during done is accepted
        start_op(0, 16'd10, 16'd20, 1'b0);
        start_op(0, 16'd1, 16'd1, 1'b0);
        wait_done(0, 1, "t4a");
        chk_out(0, "t4a", 30, 1'b0, 1'b0, 1'b0, 1'b0);
        start_op(0, 16'd7, 16'd8, 1'b0);
        wait_done(0, 2, "t4b");
        chk_out(0, "t4b", 15, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-operation aborts it
        start_op(0, 16'h55, 16'h55, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_busy_done", int'({o_busy[0], o_done[0]}), 0);
        chk_out(0, "t5", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_no_done", int'(o_done[0]), 0);
        start_op(0, 16'd2, 16'd2, 1'b0);
        wait_done(0, 2, "t5b");
        chk_out(0, "t5b", 4, 1'b0, 1'b0, 1'b0, 1'b0);

        // wide configuration: carry across group boundary and across the register
        start_op(1, 16'h0fff, 16'h0001, 1'b0);
        wait_done(1, 2, "t6");
        chk_out(1, "t6", 'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        start_op(1, 16'h0000, 16'h0001, 1'b1);
        wait_done(1, 2, "t6b");
        chk_out(1, "t6b", 'hffff, 1'b0, 1'b0, 1'b0, 1'b1);

        // single-step configurations
        start_op(2, 16'd7, 16'd1, 1'b0);
        wait_done(2, 1, "t7");
        chk_out(2, "t7", 8, 1'b0, 1'b1, 1'b0, 1'b1);
        start_op(3, 16'hf0, 16'h10, 1'b0);
        wait_done(3, 1, "t8");
        chk_out(3, "t8", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // random sweep, back-to-back on the done cycle
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 25; k++) begin
                start_op(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                wait_done(i, c_of(i), "rnd");
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
